// File: rtl/m65c02a_bus_pkg.sv
// ----------------------------------------------------------------------------
// m65c02a_bus_pkg
// Shared definitions for the M65C02A bus wait-state controller.
//   - FSM state encoding
//   - wait-state table field layout and geometry
//   - chip-enable priority encoder
// ----------------------------------------------------------------------------
package m65c02a_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_EXT  = 2'b10
    } state_t;

    // Table entry layout: [3:0] WSC, [4] ExtEn, [7:5] reserved (reads 0)
    localparam int WSC_LSB     = 0;
    localparam int WSC_W       = 4;
    localparam int EXTEN_BIT   = 4;
    localparam int ENTRY_W     = EXTEN_BIT + 1;   // only the live bits are stored

    localparam int NUM_ENTRIES = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 5;               // WSC (max 15) + pWS_Out (max 15)

    // Index of the highest set chip enable; 0 means no external chip select.
    function automatic logic [IDX_W-1:0] ce_index(input logic [15:1] ce);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            if (ce[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/m65c02a_sync2.sv
// ----------------------------------------------------------------------------
// m65c02a_sync2
// Two-flop synchronizer, asynchronously reset to 0.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronized output (2-cycle latency)
// ----------------------------------------------------------------------------
module m65c02a_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m65c02a_bus_wait_ctrl.sv
// ----------------------------------------------------------------------------
// m65c02a_bus_wait_ctrl
// Generates the core's Rdy microcycle-ready signal from the MMU chip enables,
// the MMU internal wait-state request, a programmable per-chip-select
// wait-state table and an optional synchronized external wait line.
//
// Optional feature macro: BUS_TMO_EN
//   defined   : external waits time out after pTMO cycles in EXT, pulsing
//               Bus_Err and setting a sticky flag readable on WSR_DO[7]
//               (cleared by a table read while Rdy=1).
//   undefined : EXT waits indefinitely, Bus_Err=0, WSR_DO[7]=0.
//
// Parameters:
//   pWS_Out  extra wait states when Int_WS=1 (0..15)
//   pWS_Rst  reset value of every table wait count
//   pTMO     external-wait timeout in cycles (BUS_TMO_EN only)
//
// Ports:
//   Clk, Rst          clock, asynchronous active-high reset
//   Mem_Req           core has a valid memory cycle; held while Rdy=0
//   CE[15:1]          one-hot chip enables from the MMU
//   Int_WS            MMU internal wait-state request
//   Ext_Wait          asynchronous external wait, active-high
//   Sel_WSR, WE, RE   table register port select / write / read
//   Reg_Sel[3:0]      table entry index
//   WSR_DI[7:0]       table write data
//   WSR_DO[7:0]       table read data, 0 when not reading
//   Rdy               microcycle ready (combinational)
//   Bus_Err           external-wait timeout pulse
// ----------------------------------------------------------------------------
module m65c02a_bus_wait_ctrl
    import m65c02a_bus_pkg::*;
#(
    parameter int pWS_Out = 2,
    parameter int pWS_Rst = 3,
    parameter int pTMO    = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Mem_Req,
    input  logic [15:1] CE,
    input  logic        Int_WS,
    input  logic        Ext_Wait,
    input  logic        Sel_WSR,
    input  logic        WE,
    input  logic        RE,
    input  logic [3:0]  Reg_Sel,
    input  logic [7:0]  WSR_DI,
    output logic [7:0]  WSR_DO,
    output logic        Rdy,
    output logic        Bus_Err
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ext_en_l;     // ExtEn captured when the access starts
    logic [ENTRY_W-1:0] tbl [NUM_ENTRIES];
    logic               wait_s;
    logic [IDX_W-1:0]   idx;
    logic [ENTRY_W-1:0] cur;
    logic               cur_ext_en;
    logic [CNT_W-1:0]   n_ws;
    logic               tmo_hit;
    logic               tmo_flag;
    logic               unused_di;

    m65c02a_sync2 u_ext_sync (
        .clk (Clk),
        .rst (Rst),
        .d   (Ext_Wait),
        .q   (wait_s)
    );

    // Live lookup; only consulted in IDLE, later cycles use captured values.
    assign idx        = ce_index(CE);
    assign cur        = tbl[idx];
    assign cur_ext_en = cur[EXTEN_BIT];
    assign n_ws       = CNT_W'(cur[WSC_LSB +: WSC_W]) +
                        (Int_WS ? CNT_W'(pWS_Out) : CNT_W'(0));

    // ------------------------------------------------------------------
    // External-wait timeout
    // ------------------------------------------------------------------
`ifdef BUS_TMO_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (state == ST_EXT) && Mem_Req && wait_s &&
                     (tmo_cnt == 16'(pTMO));

    // Held at 0 outside EXT, so it starts from 0 on every EXT entry.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            tmo_cnt <= '0;
        else if (state != ST_EXT)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Set wins over a same-cycle read-clear so a timeout is never lost.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            tmo_flag <= 1'b0;
        else if (tmo_hit)
            tmo_flag <= 1'b1;
        else if (Sel_WSR && RE && Rdy)
            tmo_flag <= 1'b0;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (pTMO != 0);
    assign tmo_hit    = 1'b0;
    assign tmo_flag   = 1'b0;
`endif

    assign Bus_Err = tmo_hit;

    // ------------------------------------------------------------------
    // Ready: combinational from state and current inputs
    // ------------------------------------------------------------------
    always_comb begin
        Rdy = 1'b1;
        if (!Rst && Mem_Req) begin
            case (state)
                ST_IDLE: Rdy = (n_ws == '0) && !(cur_ext_en && wait_s);
                ST_WAIT: Rdy = (cnt == '0) && !(ext_en_l && wait_s);
                ST_EXT:  Rdy = !wait_s || tmo_hit;
                default: Rdy = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ext_en_l <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Mem_Req) begin
                        ext_en_l <= cur_ext_en;
                        if (n_ws != '0) begin
                            // The IDLE cycle is the first wait, so N waits
                            // give N+1 cycles in total.
                            state <= ST_WAIT;
                            cnt   <= n_ws - CNT_W'(1);
                        end else if (cur_ext_en && wait_s) begin
                            state <= ST_EXT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!Mem_Req)
                        state <= ST_IDLE;
                    else if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    else if (ext_en_l && wait_s)
                        state <= ST_EXT;
                    else
                        state <= ST_IDLE;
                end
                ST_EXT: begin
                    if (!Mem_Req || !wait_s || tmo_hit)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wait-state table
    // ------------------------------------------------------------------
    // Gating with Rdy blocks writes while an access is stretched.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                tbl[i] <= {1'b0, WSC_W'(pWS_Rst)};
        end else if (Sel_WSR && WE && Rdy) begin
            tbl[Reg_Sel] <= WSR_DI[ENTRY_W-1:0];
        end
    end

    assign unused_di = ^WSR_DI[7:ENTRY_W];

    assign WSR_DO = (Sel_WSR && RE) ? {tmo_flag, 2'b00, tbl[Reg_Sel]} : 8'h00;

endmodule

// File: tb/tb_m65c02a_bus_wait_ctrl.sv
`timescale 1ns/1ps
// Directed bench for m65c02a_bus_wait_ctrl with a transaction-level model:
// an access is ready once its elapsed cycle count reaches the programmed
// wait count and no honoured external wait is pending.
module tb_m65c02a_bus_wait_ctrl;

    localparam int WS_OUT = 2;
    localparam int WS_RST = 3;
    localparam int P_TMO  = 8;
`ifdef BUS_TMO_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Mem_Req = 1'b0;
    logic [15:1] CE = '0;
    logic        Int_WS = 1'b0;
    logic        Ext_Wait = 1'b0;
    logic        Sel_WSR = 1'b0;
    logic        WE = 1'b0;
    logic        RE = 1'b0;
    logic [3:0]  Reg_Sel = '0;
    logic [7:0]  WSR_DI = '0;
    logic [7:0]  WSR_DO;
    logic        Rdy;
    logic        Bus_Err;

    int n_checks = 0;
    int n_errors = 0;

    m65c02a_bus_wait_ctrl #(
        .pWS_Out (WS_OUT),
        .pWS_Rst (WS_RST),
        .pTMO    (P_TMO)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Mem_Req  (Mem_Req),
        .CE       (CE),
        .Int_WS   (Int_WS),
        .Ext_Wait (Ext_Wait),
        .Sel_WSR  (Sel_WSR),
        .WE       (WE),
        .RE       (RE),
        .Reg_Sel  (Reg_Sel),
        .WSR_DI   (WSR_DI),
        .WSR_DO   (WSR_DO),
        .Rdy      (Rdy),
        .Bus_Err  (Bus_Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [4:0] mtbl [16];
    bit         m_flag = 1'b0;
    bit [1:0]   m_hist = 2'b00;   // Ext_Wait seen at the last two edges
    bit         m_acc = 1'b0;     // an access is in progress
    int         m_k = 0;          // cycles elapsed in the access
    int         m_n = 0;
    bit         m_en = 1'b0;
    int         m_hold = -1;      // first cycle held by the external wait

    function automatic int m_idx(input logic [15:1] ce);
        int r;
        bit found;
        r = 0;
        found = 1'b0;
        for (int i = 15; i >= 1; i--) begin
            if (!found && ce[i]) begin
                r = i;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic void m_live(output int n, output bit en);
        int i;
        i  = m_idx(CE);
        n  = int'(mtbl[i][3:0]) + (Int_WS ? WS_OUT : 0);
        en = mtbl[i][4];
    endfunction

    function automatic void model_out(output bit rdy, output bit berr);
        int n;
        bit en;
        m_live(n, en);
        if (m_acc) begin
            n  = m_n;
            en = m_en;
        end
        rdy  = 1'b1;
        berr = 1'b0;
        if (Rst || !Mem_Req) return;
        if (m_k < n)
            rdy = 1'b0;
        else if (en && m_hist[1]) begin
            if (TMO && m_hold >= 0 && m_k == m_hold + 1 + P_TMO)
                berr = 1'b1;
            else
                rdy = 1'b0;
        end
    endfunction

    always @(posedge Clk or posedge Rst) begin
        bit r, b;
        if (Rst) begin
            for (int i = 0; i < 16; i++) mtbl[i] = 5'(WS_RST);
            m_flag = 1'b0; m_hist = 2'b00; m_acc = 1'b0;
            m_k = 0; m_n = 0; m_en = 1'b0; m_hold = -1;
        end else begin
            model_out(r, b);
            if (Mem_Req && !r) begin
                if (!m_acc) begin
                    m_live(m_n, m_en);
                    m_acc = 1'b1;
                end
                if (m_hold < 0 && m_k >= m_n && m_en && m_hist[1]) m_hold = m_k;
                m_k++;
            end else begin
                m_acc = 1'b0; m_k = 0; m_hold = -1;
            end
            if (Sel_WSR && WE && r) mtbl[Reg_Sel] = WSR_DI[4:0];
            if (b) m_flag = 1'b1;
            else if (Sel_WSR && RE && r) m_flag = 1'b0;
            m_hist = {m_hist[0], Ext_Wait};
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge Clk) begin
        bit r, b;
        model_out(r, b);
        check("m_rdy", 32'(Rdy), 32'(r));
        check("m_bus_err", 32'(Bus_Err), 32'(b));
        if (!Rst)
            check("m_wsr_do", 32'(WSR_DO),
                  32'((Sel_WSR && RE) ? {m_flag & TMO, 2'b00, mtbl[Reg_Sel]} : 8'h00));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input string nm, input bit exp_rdy);
        @(negedge Clk);
        check(nm, 32'(Rdy), 32'(exp_rdy));
        @(posedge Clk); #1;
    endtask

    task automatic idle(input int n);
        Mem_Req = 1'b0;
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic wr(input int sel, input logic [7:0] d);
        Sel_WSR = 1'b1; WE = 1'b1; Reg_Sel = 4'(sel); WSR_DI = d;
        @(posedge Clk); #1;
        Sel_WSR = 1'b0; WE = 1'b0;
    endtask

    task automatic rd(input string nm, input int sel, input logic [7:0] exp);
        Sel_WSR = 1'b1; RE = 1'b1; Reg_Sel = 4'(sel);
        @(negedge Clk);
        check(nm, 32'(WSR_DO), 32'(exp));
        @(posedge Clk); #1;
        Sel_WSR = 1'b0; RE = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        Mem_Req = 1'b1; CE = 15'h0001;
        repeat (2) @(posedge Clk);
        #1 check("rst_rdy_held", 32'(Rdy), 32'd1);
        Mem_Req = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_rdy", 32'(Rdy), 32'd1);
        check("rst_berr", 32'(Bus_Err), 32'd0);
        check("rst_do", 32'(WSR_DO), 32'd0);
        @(posedge Clk); #1;

        // Default table: 3 waits -> 4 cycles
        Mem_Req = 1'b1; CE = 15'h0001; Int_WS = 1'b0;
        cyc("t1_c0", 0); cyc("t1_c1", 0); cyc("t1_c2", 0); cyc("t1_c3", 1);
        Mem_Req = 1'b0;
        rd("t1_rd1", 1, 8'h03);

        // Internal wait only, then zero wait
        wr(8, 8'h00);
        Mem_Req = 1'b1; CE = 15'h0080; Int_WS = 1'b1;
        cyc("t2_c0", 0); cyc("t2_c1", 0); cyc("t2_c2", 1);
        Int_WS = 1'b0;
        cyc("t2_zero", 1);
        idle(1);

        // External wait honoured, released at cycle 6
        wr(2, 8'h11);
        Ext_Wait = 1'b1;
        idle(2);
        Mem_Req = 1'b1; CE = 15'h0002;
        for (int c = 0; c <= 8; c++) begin
            if (c == 6) Ext_Wait = 1'b0;
            cyc("t3_ext", c == 8);
        end
        Mem_Req = 1'b0;
        cyc("t3_idle", 1);

        // Highest chip enable wins
        wr(3, 8'h01);
        Mem_Req = 1'b1; CE = 15'h0005;
        cyc("t4_pri0", 0); cyc("t4_pri1", 1);
        idle(1);
        // Drop Mem_Req in WAIT with Cnt=2, then a fresh 4-cycle access
        Mem_Req = 1'b1; CE = 15'h0001;
        cyc("t4_w0", 0);
        Mem_Req = 1'b0;
        cyc("t4_drop", 1);
        Mem_Req = 1'b1;
        cyc("t4_r0", 0); cyc("t4_r1", 0); cyc("t4_r2", 0); cyc("t4_r3", 1);
        idle(1);

        // Asynchronous reset in the middle of a long wait
        wr(5, 8'h0A);
        Mem_Req = 1'b1; CE = 15'h0010;
        cyc("t5_w0", 0); cyc("t5_w1", 0);
        #2 Rst = 1'b1;
        #1 check("t5_rst_rdy", 32'(Rdy), 32'd1);
        @(posedge Clk); #1;
        Mem_Req = 1'b0; Rst = 1'b0;
        rd("t5_rd5", 5, 8'h03);
        rd("t5_rd2", 2, 8'h03);
        rd("t5_rd3", 3, 8'h03);
        Mem_Req = 1'b1; CE = 15'h0001;
        cyc("t5_c0", 0); cyc("t5_c1", 0); cyc("t5_c2", 0); cyc("t5_c3", 1);
        idle(1);

        // Stuck external wait: times out only when the feature is built in
        wr(6, 8'h10);
        Ext_Wait = 1'b1;
        idle(2);
        Mem_Req = 1'b1; CE = 15'h0020;
        for (int c = 0; c <= 9; c++) begin
            @(negedge Clk);
            check("t6_rdy", 32'(Rdy), 32'(TMO && c == 9));
            check("t6_berr", 32'(Bus_Err), 32'(TMO && c == 9));
            @(posedge Clk); #1;
        end
        Mem_Req = 1'b0; Ext_Wait = 1'b0;
        rd("t6_flag", 6, TMO ? 8'h90 : 8'h10);
        rd("t6_clr", 6, 8'h10);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
